// File: rtl/s_pipe_skid.sv
// Two-entry valid/ready skid buffer: registered i_rdy, o_vld and o_dat, so no
// combinational path runs between producer and consumer.
module s_pipe_skid #(
  parameter int              SIZE    = 8,
  parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_vld,
  output logic            i_rdy,
  input  logic [SIZE-1:0] i_dat,
  output logic            o_vld,
  input  logic            o_rdy,
  output logic [SIZE-1:0] o_dat,
  output logic [1:0]      o_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      cnt_nxt;
  logic [SIZE-1:0] main_q;
  logic [SIZE-1:0] skid_q;
  logic            in_xfer;
  logic            out_xfer;

  assign in_xfer  = i_vld & i_rdy;
  assign out_xfer = o_vld & o_rdy;
  assign o_dat    = main_q;

  // NOTE: every signal assigned in always_comb gets a default first; otherwise a latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = 2'd0;
    case (state)
      EMPTY:   if (in_xfer) state_nxt = BUSY;
      BUSY: begin
        if (in_xfer && !out_xfer)      state_nxt = FULL;
        else if (!in_xfer && out_xfer) state_nxt = EMPTY;
      end
      FULL:    if (out_xfer) state_nxt = BUSY;
      default: state_nxt = EMPTY;
    endcase
    case (state_nxt)
      BUSY:    cnt_nxt = 2'd1;
      FULL:    cnt_nxt = 2'd2;
      default: cnt_nxt = 2'd0;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  // NOTE: sequential state uses non-blocking (<=) so all registers sample pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      o_vld  <= 1'b0;
      i_rdy  <= 1'b0;
      o_cnt  <= 2'd0;
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
    end else begin
      state <= state_nxt;
      o_vld <= (state_nxt != EMPTY);
      i_rdy <= (state_nxt != FULL);
      o_cnt <= cnt_nxt;
      // i_dat is only sampled on an accepted transfer, so ignored X never reaches state.
      case (state)
        EMPTY: if (in_xfer) main_q <= i_dat;
        BUSY: begin
          if (in_xfer && out_xfer) main_q <= i_dat;
          else if (in_xfer)        skid_q <= i_dat;
        end
        FULL:    if (out_xfer) main_q <= skid_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_s_pipe_skid.sv
// Self-checking bench for s_pipe_skid: directed scenarios plus a random
// valid/ready run, all checked against a FIFO scoreboard of accepted data.
module tb_s_pipe_skid;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_vld;
  logic       i_rdy;
  logic [7:0] i_dat;
  logic       o_vld;
  logic       o_rdy;
  logic [7:0] o_dat;
  logic [1:0] o_cnt;

  int total = 0;
  int bad   = 0;
  logic [7:0] q[$];

  s_pipe_skid #(.SIZE(8), .RST_VAL(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .i_dat (i_dat),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_dat (o_dat),
    .o_cnt (o_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // One clock cycle, entered and left at a falling edge. Transfers are decided
  // from the stable pre-edge handshake; the scoreboard tracks what the DUT holds.
  task automatic step(input logic vld, input logic [7:0] dat, input logic rdy,
                      output logic accepted);
    logic       stall;
    logic [7:0] held;
    logic [7:0] exp;
    i_vld = vld;
    i_dat = dat;
    o_rdy = rdy;
    #1;
    accepted = i_vld && i_rdy;
    if (o_vld && o_rdy) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        if (bad < 20) $display("FAIL pop: output transfer of %h with empty scoreboard, want none", o_dat);
      end else begin
        exp = q.pop_front();
        if (o_dat !== exp) begin
          bad++;
          if (bad < 20) $display("FAIL order: got %h want %h", o_dat, exp);
        end
      end
    end
    if (accepted) q.push_back(i_dat);
    stall = o_vld && !o_rdy;
    held  = o_dat;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (o_cnt !== 2'(q.size()) || o_vld !== (q.size() != 0) || i_rdy !== (q.size() < 2)) begin
      bad++;
      if (bad < 20) $display("FAIL occupancy: got cnt=%0d vld=%b rdy=%b want cnt=%0d", o_cnt, o_vld, i_rdy, q.size());
    end
    total++;
    if (o_cnt !== 2'(o_vld + !i_rdy)) begin
      bad++;
      if (bad < 20) $display("FAIL cnt_formula: got cnt=%0d vld=%b rdy=%b", o_cnt, o_vld, i_rdy);
    end
    if (o_vld === 1'b1 && q.size() != 0) begin
      total++;
      if (o_dat !== q[0]) begin
        bad++;
        if (bad < 20) $display("FAIL head: got %h want %h", o_dat, q[0]);
      end
    end
    if (stall) begin
      total++;
      if (o_vld !== 1'b1 || o_dat !== held) begin
        bad++;
        if (bad < 20) $display("FAIL stall_stable: got vld=%b dat=%h want vld=1 dat=%h", o_vld, o_dat, held);
      end
    end
  endtask

  task automatic drain(input int budget);
    logic acc;
    for (int i = 0; i < budget && q.size() != 0; i++) step(1'b0, 8'h00, 1'b1, acc);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left after %0d cycles, want 0", q.size(), budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    i_vld = 1'b0;
    i_dat = 8'h00;
    o_rdy = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (o_vld !== 1'b0 || i_rdy !== 1'b0 || o_cnt !== 2'd0 || o_dat !== 8'h00) begin
      bad++;
      $display("FAIL reset_async: got vld=%b rdy=%b cnt=%0d dat=%h want 0 0 0 00", o_vld, i_rdy, o_cnt, o_dat);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    i_vld = 1'b1;
    i_dat = 8'h11;
    @(posedge clk);
    #1;
    total++;
    if (i_rdy !== 1'b1 || o_vld !== 1'b0 || o_cnt !== 2'd0) begin
      bad++;
      $display("FAIL release_first_edge: got rdy=%b vld=%b cnt=%0d want 1 0 0", i_rdy, o_vld, o_cnt);
    end
    @(posedge clk);
    #1;
    total++;
    if (o_vld !== 1'b1 || o_dat !== 8'h11 || o_cnt !== 2'd1) begin
      bad++;
      $display("FAIL release_accept: got vld=%b dat=%h cnt=%0d want 1 11 1", o_vld, o_dat, o_cnt);
    end
    @(negedge clk);
    q.push_back(8'h11);
    drain(4);
  endtask

  task automatic test_streaming();
    logic acc;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b1, acc);
      total++;
      if (!acc || o_dat !== 8'(i) || o_cnt !== 2'd1 || i_rdy !== 1'b1) begin
        bad++;
        $display("FAIL stream_%0d: got acc=%b dat=%h cnt=%0d rdy=%b want 1 %h 1 1", i, acc, o_dat, o_cnt, i_rdy, 8'(i));
      end
    end
    drain(4);
  endtask

  task automatic test_backpressure();
    logic acc;
    int   pops;
    step(1'b1, 8'hA0, 1'b1, acc);
    step(1'b1, 8'hA1, 1'b0, acc);
    total++;
    if (o_cnt !== 2'd2 || i_rdy !== 1'b0 || o_dat !== 8'hA0) begin
      bad++;
      $display("FAIL skid_capture: got cnt=%0d rdy=%b dat=%h want 2 0 a0", o_cnt, i_rdy, o_dat);
    end
    step(1'b1, 8'hA2, 1'b0, acc);
    total++;
    if (acc || o_dat !== 8'hA0) begin
      bad++;
      $display("FAIL skid_hold: got acc=%b dat=%h want 0 a0", acc, o_dat);
    end
    pops = 0;
    while (!acc && pops < 4) begin
      step(1'b1, 8'hA2, 1'b1, acc);
      pops++;
    end
    total++;
    if (pops != 2) begin
      bad++;
      $display("FAIL skid_reaccept: a2 accepted after %0d cycles, want 2", pops);
    end
    total++;
    if (o_dat !== 8'hA2 || o_cnt !== 2'd1) begin
      bad++;
      $display("FAIL skid_resume: got dat=%h cnt=%0d want a2 1", o_dat, o_cnt);
    end
    drain(4);
  endtask

  task automatic test_drain();
    logic acc;
    step(1'b1, 8'h55, 1'b0, acc);
    step(1'b1, 8'h66, 1'b0, acc);
    total++;
    if (o_cnt !== 2'd2) begin
      bad++;
      $display("FAIL drain_full: got cnt=%0d want 2", o_cnt);
    end
    step(1'b0, 8'h00, 1'b1, acc);
    total++;
    if (o_dat !== 8'h66 || o_vld !== 1'b1) begin
      bad++;
      $display("FAIL drain_second: got dat=%h vld=%b want 66 1", o_dat, o_vld);
    end
    step(1'b0, 8'h00, 1'b1, acc);
    total++;
    if (o_vld !== 1'b0 || o_cnt !== 2'd0 || i_rdy !== 1'b1) begin
      bad++;
      $display("FAIL drain_empty: got vld=%b cnt=%0d rdy=%b want 0 0 1", o_vld, o_cnt, i_rdy);
    end
  endtask

  task automatic test_random();
    logic       acc;
    logic [7:0] cnt8 = 8'h00;
    int         sent = 0;
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), cnt8, 1'($urandom_range(0, 1)), acc);
      if (acc) begin
        cnt8++;
        sent++;
      end
    end
    drain(8);
    total++;
    if (sent < 1000) begin
      bad++;
      $display("FAIL random_throughput: got %0d transfers, want at least 1000", sent);
    end
  endtask

  task automatic test_reset_full();
    logic acc;
    step(1'b1, 8'hC1, 1'b0, acc);
    step(1'b1, 8'hC2, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (o_vld !== 1'b0 || o_cnt !== 2'd0 || i_rdy !== 1'b0 || o_dat !== 8'h00) begin
      bad++;
      $display("FAIL reset_full: got vld=%b cnt=%0d rdy=%b dat=%h want 0 0 0 00", o_vld, o_cnt, i_rdy, o_dat);
    end
    q.delete();
    i_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, acc);
    total++;
    if (o_vld !== 1'b0 || o_cnt !== 2'd0) begin
      bad++;
      $display("FAIL reset_full_stale: got vld=%b cnt=%0d want 0 0", o_vld, o_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_drain();
    test_random();
    test_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
